// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
// Op encodings, FSM state type and small op-decode helpers.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath on {acc,q}: shift-add multiply step
// (acc += b when q[0], then shift right) or restoring-divide step (shift left, trial subtract).
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   acc_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    assign sum     = acc_in + {1'b0, (q_in[0] ? b : '0)};
    assign shifted = {acc_in[WIDTH-1:0], q_in[WIDTH-1]};
    // Extra top bit of diff is the borrow: set means the trial subtract went negative.
    assign diff    = {1'b0, shifted} - {2'b00, b};

    always_comb begin
        acc_out = '0;
        q_out   = '0;
        if (is_div) begin
            if (diff[WIDTH+1]) begin
                acc_out = shifted;
                q_out   = {q_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = diff[WIDTH:0];
                q_out   = {q_in[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_out = {1'b0, sum[WIDTH:1]};
            q_out   = {sum[0], q_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Works on magnitudes, then applies two's-complement sign fix before writing HI/LO.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e_start,
    input  logic [1:0]       e_op,
    input  logic [WIDTH-1:0] e_rs,
    input  logic [WIDTH-1:0] e_rt,
    input  logic             e_flush,
    output logic             e_busy,
    output logic             e_done,
    output logic             e_divzero,
    output logic [WIDTH-1:0] e_hi,
    output logic [WIDTH-1:0] e_lo
);

    state_t             state;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   rs_q;
    logic [WIDTH-1:0]   rt_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   b_q;
    logic               neg_q;
    logic               rneg_q;
    logic               dz_q;

    logic [WIDTH:0]     acc_step;
    logic [WIDTH-1:0]   q_step;
    logic               a_neg;
    logic               b_neg;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (op_is_div(op_q)),
        .acc_in  (acc_q),
        .q_in    (q_q),
        .b       (b_q),
        .acc_out (acc_step),
        .q_out   (q_step)
    );

    assign a_neg    = op_is_signed(op_q) & rs_q[WIDTH-1];
    assign b_neg    = op_is_signed(op_q) & rt_q[WIDTH-1];
    assign prod     = {acc_q[WIDTH-1:0], q_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign rem      = acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -rem : rem;
    assign quo_fix  = neg_q ? -q_q : q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MULTU;
            rs_q      <= '0;
            rt_q      <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            e_busy    <= 1'b0;
            e_done    <= 1'b0;
            e_divzero <= 1'b0;
            e_hi      <= '0;
            e_lo      <= '0;
        end else begin
            e_done <= 1'b0;
            if (e_flush) begin
                state  <= S_IDLE;
                e_busy <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (e_start) begin
                            op_q      <= e_op;
                            rs_q      <= e_rs;
                            rt_q      <= e_rt;
                            e_divzero <= 1'b0;
                            e_busy    <= 1'b1;
                            state     <= S_PREP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_PREP: begin
                        acc_q  <= '0;
                        // Multiply iterates over the multiplier (rt); divide over the dividend (rs).
                        if (op_is_div(op_q)) begin
                            q_q <= mag(rs_q, a_neg);
                            b_q <= mag(rt_q, b_neg);
                        end else begin
                            q_q <= mag(rt_q, b_neg);
                            b_q <= mag(rs_q, a_neg);
                        end
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        dz_q   <= op_is_div(op_q) && (rt_q == '0);
                        cnt_q  <= CNT_W'(WIDTH - 1);
                        state  <= S_RUN;
                    end
                    S_RUN: begin
                        acc_q <= acc_step;
                        q_q   <= q_step;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (dz_q) begin
                            e_hi <= rs_q;
                            e_lo <= '1;
                        end else if (op_is_div(op_q)) begin
                            e_hi <= rem_fix;
                            e_lo <= quo_fix;
                        end else begin
                            {e_hi, e_lo} <= prod_fix;
                        end
                        e_divzero <= dz_q;
                        e_done    <= 1'b1;
                        e_busy    <= 1'b0;
                        state     <= S_DONE;
                    end
                    default: begin
                        state  <= S_IDLE;
                        e_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner ops, randomized ops against
// an arithmetic reference model, back-to-back launch, ignored start, flush and async reset.
module tb_muldiv_seq;

    localparam int W = 32;
    localparam int LAT = 34;  // negedges from the PREP cycle to the e_done cycle

    logic         clk = 1'b0;
    logic         rst;
    logic         e_start;
    logic [1:0]   e_op;
    logic [W-1:0] e_rs;
    logic [W-1:0] e_rt;
    logic         e_flush;
    logic         e_busy;
    logic         e_done;
    logic         e_divzero;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_seq #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .e_start   (e_start),
        .e_op      (e_op),
        .e_rs      (e_rs),
        .e_rt      (e_rt),
        .e_flush   (e_flush),
        .e_busy    (e_busy),
        .e_done    (e_done),
        .e_divzero (e_divzero),
        .e_hi      (e_hi),
        .e_lo      (e_lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] hi,
                                  output logic [W-1:0] lo, output logic dz);
        longint     sa;
        longint     sb;
        logic [63:0] p;
        longint     qt;
        longint     rm;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                p = {32'h0, a} * {32'h0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                p = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    dz = 1'b1;
                    hi = a;
                    lo = '1;
                end else if (op == 2'b10) begin
                    hi = a % b;
                    lo = a / b;
                end else begin
                    qt = sa / sb;
                    rm = sa % sb;
                    hi = rm[31:0];
                    lo = qt[31:0];
                end
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the PREP cycle.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        e_start = 1'b1;
        e_op    = op;
        e_rs    = a;
        e_rt    = b;
        @(negedge clk);
        e_start = 1'b0;
        e_rs    = $urandom;
        e_rt    = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (e_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Launch, wait for completion and compare; returns at the negedge of the DONE cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [W-1:0] xh;
        logic [W-1:0] xl;
        logic         xz;
        int           n;
        model(op, a, b, xh, xl, xz);
        start_op(op, a, b);
        check_eq({tag, " busy_prep"}, 64'(e_busy), 64'd1);
        check_eq({tag, " dz_clear"}, 64'(e_divzero), 64'd0);
        wait_done(n);
        check_eq({tag, " latency"}, 64'(n), 64'(LAT));
        check_eq({tag, " busy_done"}, 64'(e_busy), 64'd0);
        check_eq({tag, " hi"}, 64'(e_hi), 64'(xh));
        check_eq({tag, " lo"}, 64'(e_lo), 64'(xl));
        check_eq({tag, " divzero"}, 64'(e_divzero), 64'(xz));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0007};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        if ($urandom_range(0, 1) == 0) return W'($urandom_range(0, 1000));
        return $urandom;
    endfunction

    initial begin
        int           n;
        int           dones;
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;
        logic [W-1:0] xh;
        logic [W-1:0] xl;
        logic         xz;

        rst     = 1'b1;
        e_start = 1'b0;
        e_flush = 1'b0;
        e_op    = 2'b00;
        e_rs    = '0;
        e_rt    = '0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", 64'(e_busy), 64'd0);
        check_eq("reset done", 64'(e_done), 64'd0);
        check_eq("reset dz", 64'(e_divzero), 64'd0);
        check_eq("reset hilo", {e_hi, e_lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("multu_max const", {e_hi, e_lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7);
        check_eq("mult_neg const", {e_hi, e_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2);
        check_eq("div_neg const", {e_hi, e_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge clk);
        run_op("divu", 2'b10, 32'd100, 32'd7);
        check_eq("divu const", {e_hi, e_lo}, {32'd2, 32'd14});
        @(negedge clk);
        run_op("divu_zero", 2'b10, 32'd5, 32'd0);
        check_eq("divu_zero flag", 64'(e_divzero), 64'd1);
        @(negedge clk);
        check_eq("dz holds", 64'(e_divzero), 64'd1);
        run_op("div_zero_s", 2'b11, 32'hFFFF_FFF0, 32'd0);
        @(negedge clk);
        run_op("div_min", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("div_min const", {e_hi, e_lo}, {32'h0, 32'h8000_0000});

        // Back-to-back: launch in the DONE cycle.
        run_op("b2b_a", 2'b01, 32'h1234_5678, 32'h8765_4321);
        run_op("b2b_b", 2'b11, 32'h8765_4321, 32'h0000_1234);

        // Second start during RUN is ignored.
        @(negedge clk);
        model(2'b10, 32'd1000, 32'd33, xh, xl, xz);
        start_op(2'b10, 32'd1000, 32'd33);
        repeat (5) @(negedge clk);
        start_op(2'b00, 32'd3, 32'd3);
        wait_done(n);
        check_eq("ign latency", 64'(n), 64'(LAT - 6));
        check_eq("ign hilo", {e_hi, e_lo}, {xh, xl});
        @(negedge clk);
        check_eq("ign idle busy", 64'(e_busy), 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (e_done) dones++;
        end
        check_eq("ign no extra done", 64'(dones), 64'd0);

        // Flush at RUN cycle 10.
        hold_hi = e_hi;
        hold_lo = e_lo;
        start_op(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        repeat (10) @(negedge clk);
        check_eq("flush pre busy", 64'(e_busy), 64'd1);
        e_flush = 1'b1;
        @(negedge clk);
        e_flush = 1'b0;
        check_eq("flush busy", 64'(e_busy), 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (e_done) dones++;
        end
        check_eq("flush no done", 64'(dones), 64'd0);
        check_eq("flush hilo", {e_hi, e_lo}, {hold_hi, hold_lo});

        // Flush wins over start in the same cycle.
        e_flush = 1'b1;
        start_op(2'b00, 32'd9, 32'd9);
        e_flush = 1'b0;
        check_eq("flush prio busy", 64'(e_busy), 64'd0);
        repeat (3) @(negedge clk);
        check_eq("flush prio idle", 64'(e_busy), 64'd0);

        // Async reset mid-RUN.
        run_op("pre_rst", 2'b00, 32'h0001_0000, 32'h0001_0000);
        @(negedge clk);
        start_op(2'b11, 32'h7000_0000, 32'h0000_0003);
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("rst busy", 64'(e_busy), 64'd0);
        check_eq("rst hilo", {e_hi, e_lo}, 64'd0);
        check_eq("rst flags", {62'd0, e_done, e_divzero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            run_op($sformatf("rnd%0d", i), op, a, b);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
